// File: rtl/exc_ctrl_if.sv
// Pipeline/CP0 bundle for the exception sequencer: request and ERET inputs on
// one side, CP0 write strobes and PC redirect on the other.
interface exc_ctrl_if #(
  parameter int NUM_IRQ = 6
);
  logic               if_adel;
  logic [31:0]        if_pc;
  logic               id_ri;
  logic               id_sys;
  logic               id_bp;
  logic [31:0]        id_pc;
  logic               ex_ov;
  logic [31:0]        ex_pc;
  logic               mem_adel;
  logic               mem_ades;
  logic [31:0]        mem_pc;
  logic [31:0]        mem_addr;
  logic [NUM_IRQ-1:0] irq;
  logic               status_ie;
  logic               status_exl;
  logic               eret;
  logic [31:0]        cp0_epc;

  logic               flush;
  logic               busy;
  logic               cp0_exc_we;
  logic [31:0]        cp0_epc_o;
  logic [4:0]         cp0_exccode;
  logic               cp0_bv_we;
  logic [31:0]        cp0_badvaddr;
  logic               cp0_set_exl;
  logic               cp0_clr_exl;
  logic               pc_redirect;
  logic [31:0]        pc_target;

  modport master (
    output if_adel, if_pc, id_ri, id_sys, id_bp, id_pc, ex_ov, ex_pc,
           mem_adel, mem_ades, mem_pc, mem_addr, irq, status_ie, status_exl,
           eret, cp0_epc,
    input  flush, busy, cp0_exc_we, cp0_epc_o, cp0_exccode, cp0_bv_we,
           cp0_badvaddr, cp0_set_exl, cp0_clr_exl, pc_redirect, pc_target
  );

  modport slave (
    input  if_adel, if_pc, id_ri, id_sys, id_bp, id_pc, ex_ov, ex_pc,
           mem_adel, mem_ades, mem_pc, mem_addr, irq, status_ie, status_exl,
           eret, cp0_epc,
    output flush, busy, cp0_exc_we, cp0_epc_o, cp0_exccode, cp0_bv_we,
           cp0_badvaddr, cp0_set_exl, cp0_clr_exl, pc_redirect, pc_target
  );
endinterface

// File: rtl/exc_ctrl.sv
// Exception/ERET sequencer: priority select, flush -> commit -> redirect, ERET.
// Optional macro IRQ_SYNC_EN inserts a 2-flop synchroniser on the irq lines.
module exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
  parameter int          FLUSH_CYCLES = 2,
  parameter int          NUM_IRQ      = 6
) (
  input  logic     clk,
  input  logic     rst_n,
  exc_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FLUSH    = 3'd1,
    COMMIT   = 3'd2,
    REDIRECT = 3'd3,
    ERET     = 3'd4
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

  state_t       state, state_nxt;
  logic [3:0]   cnt, cnt_nxt;

  logic [4:0]   code_q, code_nxt;
  logic [31:0]  epc_q, epc_nxt;
  logic [31:0]  bva_q, bva_nxt;
  logic         bv_q, bv_nxt;
  logic         exl_q, exl_nxt;

  logic [NUM_IRQ-1:0] irq_s;
  logic         irq_pend;
  logic         req;
  logic [4:0]   req_code;
  logic [31:0]  req_epc;
  logic         req_bv;
  logic [31:0]  req_bva;

  logic         flush_nxt, busy_nxt, exc_we_nxt, bv_we_nxt;
  logic         set_exl_nxt, clr_exl_nxt, redirect_nxt;
  logic [31:0]  epc_o_nxt, badvaddr_nxt, target_nxt;
  logic [4:0]   exccode_nxt;

`ifdef IRQ_SYNC_EN
  logic [NUM_IRQ-1:0] irq_meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_meta <= '0;
      irq_s    <= '0;
    end else begin
      irq_meta <= bus.irq;
      irq_s    <= irq_meta;
    end
  end
`else
  assign irq_s = bus.irq;
`endif

  // Request priority: interrupt, then oldest pipeline stage first.
  always_comb begin
    irq_pend = (|irq_s) & bus.status_ie & ~bus.status_exl;
    req      = 1'b1;
    req_code = 5'd0;
    req_epc  = 32'd0;
    req_bv   = 1'b0;
    req_bva  = 32'd0;
    if (irq_pend) begin
      req_code = 5'd0;
      req_epc  = bus.mem_pc;
    end else if (bus.mem_adel) begin
      req_code = 5'd4;
      req_epc  = bus.mem_pc;
      req_bv   = 1'b1;
      req_bva  = bus.mem_addr;
    end else if (bus.mem_ades) begin
      req_code = 5'd5;
      req_epc  = bus.mem_pc;
      req_bv   = 1'b1;
      req_bva  = bus.mem_addr;
    end else if (bus.ex_ov) begin
      req_code = 5'd12;
      req_epc  = bus.ex_pc;
    end else if (bus.id_ri) begin
      req_code = 5'd10;
      req_epc  = bus.id_pc;
    end else if (bus.id_sys) begin
      req_code = 5'd8;
      req_epc  = bus.id_pc;
    end else if (bus.id_bp) begin
      req_code = 5'd9;
      req_epc  = bus.id_pc;
    end else if (bus.if_adel) begin
      req_code = 5'd4;
      req_epc  = bus.if_pc;
      req_bv   = 1'b1;
      req_bva  = bus.if_pc;
    end else begin
      req      = 1'b0;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    code_nxt  = code_q;
    epc_nxt   = epc_q;
    bva_nxt   = bva_q;
    bv_nxt    = bv_q;
    exl_nxt   = exl_q;
    unique case (state)
      IDLE: begin
        if (req) begin
          state_nxt = FLUSH;
          cnt_nxt   = CNT_INIT;
          code_nxt  = req_code;
          epc_nxt   = req_epc;
          bva_nxt   = req_bva;
          bv_nxt    = req_bv;
          exl_nxt   = bus.status_exl;
        end else if (bus.eret) begin
          state_nxt = ERET;
        end
      end
      FLUSH: begin
        if (cnt == 4'd0) state_nxt = COMMIT;
        else             cnt_nxt   = cnt - 4'd1;
      end
      COMMIT:   state_nxt = REDIRECT;
      REDIRECT: state_nxt = IDLE;
      ERET:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase

    // Outputs are decoded from the next state so they register with it.
    busy_nxt     = (state_nxt != IDLE);
    flush_nxt    = (state_nxt == FLUSH) || (state_nxt == COMMIT) || (state_nxt == ERET);
    exc_we_nxt   = (state_nxt == COMMIT);
    set_exl_nxt  = (state_nxt == COMMIT);
    bv_we_nxt    = (state_nxt == COMMIT) && bv_nxt;
    clr_exl_nxt  = (state_nxt == ERET);
    redirect_nxt = (state_nxt == REDIRECT) || (state_nxt == ERET);
    epc_o_nxt    = 32'd0;
    exccode_nxt  = 5'd0;
    badvaddr_nxt = 32'd0;
    target_nxt   = 32'd0;
    if (state_nxt == COMMIT) begin
      // Nested exception under EXL keeps the original EPC.
      epc_o_nxt   = exl_nxt ? bus.cp0_epc : epc_nxt;
      exccode_nxt = code_nxt;
      if (bv_nxt) badvaddr_nxt = bva_nxt;
    end
    if (state_nxt == REDIRECT) target_nxt = EXC_VECTOR;
    if (state_nxt == ERET)     target_nxt = bus.cp0_epc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      cnt              <= 4'd0;
      code_q           <= 5'd0;
      epc_q            <= 32'd0;
      bva_q            <= 32'd0;
      bv_q             <= 1'b0;
      exl_q            <= 1'b0;
      bus.flush        <= 1'b0;
      bus.busy         <= 1'b0;
      bus.cp0_exc_we   <= 1'b0;
      bus.cp0_epc_o    <= 32'd0;
      bus.cp0_exccode  <= 5'd0;
      bus.cp0_bv_we    <= 1'b0;
      bus.cp0_badvaddr <= 32'd0;
      bus.cp0_set_exl  <= 1'b0;
      bus.cp0_clr_exl  <= 1'b0;
      bus.pc_redirect  <= 1'b0;
      bus.pc_target    <= 32'd0;
    end else begin
      state            <= state_nxt;
      cnt              <= cnt_nxt;
      code_q           <= code_nxt;
      epc_q            <= epc_nxt;
      bva_q            <= bva_nxt;
      bv_q             <= bv_nxt;
      exl_q            <= exl_nxt;
      bus.flush        <= flush_nxt;
      bus.busy         <= busy_nxt;
      bus.cp0_exc_we   <= exc_we_nxt;
      bus.cp0_epc_o    <= epc_o_nxt;
      bus.cp0_exccode  <= exccode_nxt;
      bus.cp0_bv_we    <= bv_we_nxt;
      bus.cp0_badvaddr <= badvaddr_nxt;
      bus.cp0_set_exl  <= set_exl_nxt;
      bus.cp0_clr_exl  <= clr_exl_nxt;
      bus.pc_redirect  <= redirect_nxt;
      bus.pc_target    <= target_nxt;
    end
  end

endmodule

// File: tb/tb_exc_ctrl.sv
// Self-checking bench for exc_ctrl: directed scenarios plus randomized requests
// compared against a cycle-indexed reference of the exception/ERET sequences.
module tb_exc_ctrl;

  localparam logic [31:0] VEC = 32'hBFC0_0380;
  localparam int F = 2;
`ifdef IRQ_SYNC_EN
  localparam int IRQ_LAT = 2;
`else
  localparam int IRQ_LAT = 0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  exc_ctrl_if #(.NUM_IRQ(6)) bus();

  exc_ctrl #(.EXC_VECTOR(VEC), .FLUSH_CYCLES(F), .NUM_IRQ(6)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  typedef logic [107:0] snap_t;
  typedef struct packed {
    logic        vld;
    logic [4:0]  code;
    logic [31:0] epc;
    logic        bv;
    logic [31:0] bva;
  } exc_t;

  function automatic snap_t snap();
    return {bus.flush, bus.busy, bus.cp0_exc_we, bus.cp0_epc_o, bus.cp0_exccode,
            bus.cp0_bv_we, bus.cp0_badvaddr, bus.cp0_set_exl, bus.cp0_clr_exl,
            bus.pc_redirect, bus.pc_target};
  endfunction

  function automatic snap_t mk(input logic fl, input logic bz, input logic we,
                               input logic [31:0] epc, input logic [4:0] code,
                               input logic bvwe, input logic [31:0] bva,
                               input logic sx, input logic cx, input logic rd,
                               input logic [31:0] tgt);
    return {fl, bz, we, epc, code, bvwe, bva, sx, cx, rd, tgt};
  endfunction

  // Expected outputs k cycles after an exception is accepted (k = 1 first FLUSH).
  function automatic snap_t exc_expect(input int k, input exc_t x, input logic exl,
                                       input logic [31:0] cur_epc);
    if (k <= F)     return mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    if (k == F + 1) return mk(1, 1, 1, exl ? cur_epc : x.epc, x.code, x.bv,
                              x.bv ? x.bva : 32'd0, 1, 0, 0, 0);
    if (k == F + 2) return mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, VEC);
    return '0;
  endfunction

  // Priority pick straight from the exception table.
  function automatic exc_t model_pick(input logic irq_seen);
    exc_t x;
    x = '0;
    x.vld = 1'b1;
    if (irq_seen && bus.status_ie && !bus.status_exl) begin x.code = 0; x.epc = bus.mem_pc; end
    else if (bus.mem_adel) begin x.code = 4; x.epc = bus.mem_pc; x.bv = 1; x.bva = bus.mem_addr; end
    else if (bus.mem_ades) begin x.code = 5; x.epc = bus.mem_pc; x.bv = 1; x.bva = bus.mem_addr; end
    else if (bus.ex_ov)    begin x.code = 12; x.epc = bus.ex_pc; end
    else if (bus.id_ri)    begin x.code = 10; x.epc = bus.id_pc; end
    else if (bus.id_sys)   begin x.code = 8;  x.epc = bus.id_pc; end
    else if (bus.id_bp)    begin x.code = 9;  x.epc = bus.id_pc; end
    else if (bus.if_adel)  begin x.code = 4; x.epc = bus.if_pc; x.bv = 1; x.bva = bus.if_pc; end
    else x.vld = 1'b0;
    return x;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    bus.if_adel = 0; bus.id_ri = 0; bus.id_sys = 0; bus.id_bp = 0; bus.ex_ov = 0;
    bus.mem_adel = 0; bus.mem_ades = 0; bus.irq = '0; bus.eret = 0;
  endtask

  task automatic test_reset();
    snap_t e;
    clear_reqs();
    bus.if_pc = 32'h0; bus.id_pc = 32'h0; bus.ex_pc = 32'h0; bus.mem_pc = 32'h0;
    bus.mem_addr = 32'h0; bus.cp0_epc = 32'h0; bus.status_ie = 0; bus.status_exl = 0;
    rst_n = 1'b0;
    bus.id_sys = 1'b1;
    tick(); tick();
    e = '0;
    checks++;
    if (snap() !== e) begin errors++; $display("FAIL reset_hold got %h want %h", snap(), e); end
    clear_reqs();
    rst_n = 1'b1;
    tick();
    checks++;
    if (snap() !== e) begin errors++; $display("FAIL reset_release got %h want %h", snap(), e); end
  endtask

  task automatic test_syscall();
    exc_t x;
    snap_t e;
    bus.status_ie = 0; bus.status_exl = 0;
    bus.id_sys = 1; bus.id_pc = 32'h0040_0010;
    x = '{vld: 1, code: 5'd8, epc: 32'h0040_0010, bv: 0, bva: 32'd0};
    tick();
    clear_reqs();
    for (int k = 1; k <= F + 3; k++) begin
      e = exc_expect(k, x, 1'b0, bus.cp0_epc);
      checks++;
      if (snap() !== e) begin errors++; $display("FAIL syscall k=%0d got %h want %h", k, snap(), e); end
      tick();
    end
  endtask

  task automatic test_multi();
    exc_t x;
    snap_t e;
    bus.mem_ades = 1; bus.ex_ov = 1; bus.if_adel = 1;
    bus.mem_addr = 32'h1000_0003; bus.mem_pc = 32'h0040_0200;
    bus.ex_pc = 32'h0040_0204; bus.if_pc = 32'h0040_020C;
    x = '{vld: 1, code: 5'd5, epc: 32'h0040_0200, bv: 1, bva: 32'h1000_0003};
    tick();
    clear_reqs();
    for (int k = 1; k <= F + 3; k++) begin
      e = exc_expect(k, x, 1'b0, bus.cp0_epc);
      checks++;
      if (snap() !== e) begin errors++; $display("FAIL multi k=%0d got %h want %h", k, snap(), e); end
      tick();
    end
  endtask

  task automatic test_irq();
    exc_t x;
    snap_t e;
    bus.status_ie = 1; bus.status_exl = 0;
    bus.mem_pc = 32'h0040_0300;
    bus.irq = 6'b000100;
    x = '{vld: 1, code: 5'd0, epc: 32'h0040_0300, bv: 0, bva: 32'd0};
    for (int c = 1; c <= IRQ_LAT + 1; c++) begin
      tick();
      checks++;
      if (bus.flush !== (c == IRQ_LAT + 1)) begin
        errors++; $display("FAIL irq_latency c=%0d got %b want %b", c, bus.flush, c == IRQ_LAT + 1);
      end
    end
    bus.irq = '0;
    for (int k = 2; k <= F + 3; k++) begin
      tick();
      e = exc_expect(k, x, 1'b0, bus.cp0_epc);
      checks++;
      if (snap() !== e) begin errors++; $display("FAIL irq k=%0d got %h want %h", k, snap(), e); end
    end
    bus.status_exl = 1;
    bus.irq = 6'b000100;
    for (int c = 1; c <= IRQ_LAT + 3; c++) begin
      tick();
      e = '0;
      checks++;
      if (snap() !== e) begin errors++; $display("FAIL irq_masked c=%0d got %h want %h", c, snap(), e); end
    end
    bus.irq = '0; bus.status_ie = 0; bus.status_exl = 0;
    tick(); tick(); tick();
  endtask

  task automatic test_eret();
    exc_t x;
    snap_t e;
    bus.cp0_epc = 32'h0040_0100;
    bus.eret = 1;
    tick();
    clear_reqs();
    e = mk(1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 32'h0040_0100);
    checks++;
    if (snap() !== e) begin errors++; $display("FAIL eret got %h want %h", snap(), e); end
    tick();
    e = '0;
    checks++;
    if (snap() !== e) begin errors++; $display("FAIL eret_done got %h want %h", snap(), e); end
    bus.eret = 1; bus.id_bp = 1; bus.id_pc = 32'h0040_0400;
    x = '{vld: 1, code: 5'd9, epc: 32'h0040_0400, bv: 0, bva: 32'd0};
    tick();
    clear_reqs();
    for (int k = 1; k <= F + 3; k++) begin
      e = exc_expect(k, x, 1'b0, bus.cp0_epc);
      checks++;
      if (snap() !== e) begin errors++; $display("FAIL eret_vs_bp k=%0d got %h want %h", k, snap(), e); end
      tick();
    end
  endtask

  task automatic test_busy_ignore();
    int commits;
    logic [4:0] code_seen;
    logic [31:0] epc_seen;
    commits = 0; code_seen = '0; epc_seen = '0;
    bus.id_sys = 1; bus.id_pc = 32'h0040_0500;
    tick();
    clear_reqs();
    bus.id_ri = 1; bus.id_pc = 32'h0040_0600; bus.eret = 1;
    tick();
    clear_reqs();
    for (int c = 0; c < 8; c++) begin
      if (bus.cp0_exc_we === 1'b1) begin
        commits++; code_seen = bus.cp0_exccode; epc_seen = bus.cp0_epc_o;
      end
      tick();
    end
    checks++;
    if (commits != 1) begin errors++; $display("FAIL busy_commits got %0d want 1", commits); end
    checks++;
    if (code_seen !== 5'd8 || epc_seen !== 32'h0040_0500) begin
      errors++; $display("FAIL busy_commit got code %0d epc %h want 8 00400500", code_seen, epc_seen);
    end
  endtask

  task automatic test_reset_mid();
    int events;
    snap_t e;
    events = 0;
    e = '0;
    bus.id_ri = 1; bus.id_pc = 32'h0040_0700;
    tick();
    clear_reqs();
    rst_n = 1'b0;
    #1;
    checks++;
    if (snap() !== e) begin errors++; $display("FAIL reset_mid got %h want %h", snap(), e); end
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (bus.cp0_exc_we === 1'b1 || bus.pc_redirect === 1'b1 || bus.flush === 1'b1) events++;
    end
    checks++;
    if (events != 0) begin errors++; $display("FAIL reset_mid_events got %0d want 0", events); end
  endtask

  task automatic test_random();
    exc_t x;
    snap_t e;
    logic exl;
    logic [31:0] cur_epc;
    for (int it = 0; it < 40; it++) begin
      bus.if_adel  = ($urandom_range(0, 5) == 0);
      bus.id_ri    = ($urandom_range(0, 5) == 0);
      bus.id_sys   = ($urandom_range(0, 5) == 0);
      bus.id_bp    = ($urandom_range(0, 5) == 0);
      bus.ex_ov    = ($urandom_range(0, 5) == 0);
      bus.mem_adel = ($urandom_range(0, 6) == 0);
      bus.mem_ades = ($urandom_range(0, 6) == 0);
      bus.eret     = ($urandom_range(0, 2) == 0);
      bus.status_ie  = $urandom_range(0, 1);
      bus.status_exl = $urandom_range(0, 1);
`ifdef IRQ_SYNC_EN
      bus.irq = '0;
`else
      bus.irq = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
`endif
      bus.if_pc = $urandom; bus.id_pc = $urandom; bus.ex_pc = $urandom;
      bus.mem_pc = $urandom; bus.mem_addr = $urandom; bus.cp0_epc = $urandom;
      x = model_pick(|bus.irq);
      exl = bus.status_exl;
      cur_epc = bus.cp0_epc;
      tick();
      clear_reqs();
      if (x.vld) begin
        for (int k = 1; k <= F + 3; k++) begin
          e = exc_expect(k, x, exl, cur_epc);
          checks++;
          if (snap() !== e) begin errors++; $display("FAIL rand_exc it=%0d k=%0d got %h want %h", it, k, snap(), e); end
          tick();
        end
      end else if (snap()[107] === 1'b1 || bus.cp0_clr_exl === 1'b1) begin
        e = mk(1, 1, 0, 0, 0, 0, 0, 0, 1, 1, cur_epc);
        checks++;
        if (snap() !== e) begin errors++; $display("FAIL rand_eret it=%0d got %h want %h", it, snap(), e); end
        tick();
      end else begin
        e = '0;
        checks++;
        if (snap() !== e) begin errors++; $display("FAIL rand_idle it=%0d got %h want %h", it, snap(), e); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_syscall();
    test_multi();
    test_irq();
    test_eret();
    test_busy_ignore();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/exc_ctrl.md
Name: exc_ctrl

Overview:
Exception/ERET sequencer in front of the CP0 register file. Collects exception requests from the IF/ID/EX/MEM stages and the interrupt lines, and selects one by priority. It then runs a fixed flush → commit → redirect sequence that writes EPC/Cause/BadVAddr and the EXL bit in CP0 and steers the PC mux. It also sequences ERET back to the saved EPC.

Parameters:
EXC_VECTOR, 32'hBFC0_0380, handler entry address driven on pc_target for exceptions
FLUSH_CYCLES, 2, cycles flush is held before the CP0 commit (1..15)
NUM_IRQ, 6, number of hardware interrupt lines

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
if_adel  in  1  IF fetch address error
if_pc  in  32  PC of IF instruction (also the bad address for if_adel)
id_ri, id_sys, id_bp  in  1 each  reserved instruction / SYSCALL / BREAK in ID
id_pc  in  32  PC of ID instruction
ex_ov  in  1  EX arithmetic overflow
ex_pc  in  32  PC of EX instruction
mem_adel, mem_ades  in  1 each  load/store address error in MEM
mem_pc  in  32  PC of MEM instruction
mem_addr  in  32  faulting data address
irq  in  NUM_IRQ  level interrupt requests
status_ie, status_exl  in  1 each  CP0 Status IE/EXL bits
eret  in  1  ERET decoded in MEM
cp0_epc  in  32  current EPC value from CP0
flush  out  1  flush IF..MEM pipeline registers
busy  out  1  sequencer not idle; front end stalls
cp0_exc_we  out  1  one-cycle pulse: write EPC and Cause.ExcCode
cp0_epc_o  out  32  EPC value to write
cp0_exccode  out  5  ExcCode to write
cp0_bv_we  out  1  one-cycle pulse: write BadVAddr
cp0_badvaddr  out  32  BadVAddr value
cp0_set_exl, cp0_clr_exl  out  1 each  one-cycle EXL set/clear pulses
pc_redirect  out  1  one-cycle pulse: PC takes pc_target
pc_target  out  32  redirect address

Behaviour:
- Reset: state IDLE, counter 0, all latched fields 0. Every output is 0, including pc_target and cp0_* buses.
- int_pend = |irq_s & status_ie & ~status_exl. irq_s is irq, or its synchronised copy (see Optional Feature).
- Priority, evaluated in IDLE only, highest first:
  - int_pend: code 0, EPC = mem_pc
  - mem_adel: code 4, EPC = mem_pc, BadVAddr = mem_addr
  - mem_ades: code 5, EPC = mem_pc, BadVAddr = mem_addr
  - ex_ov: code 12, EPC = ex_pc
  - id_ri: code 10; id_sys: code 8; id_bp: code 9; EPC = id_pc for all three, checked in that order
  - if_adel: code 4, EPC = if_pc, BadVAddr = if_pc
- States:
  - IDLE:
    - Any request: latch code/EPC/BadVAddr/bv flag, go FLUSH, counter = FLUSH_CYCLES-1.
    - Else if eret: go ERET.
    - Exception and eret in the same cycle: exception wins, eret dropped.
  - FLUSH: flush=1, busy=1. Decrement the counter; at 0 go COMMIT.
  - COMMIT: one cycle, busy=1, flush=1.
    - cp0_exc_we=1 with latched EPC/code, unless status_exl was 1 at capture. In that case EPC is not overwritten and only the code is written; cp0_exc_we stays 1 and cp0_epc_o = cp0_epc.
    - cp0_bv_we=1 iff bv flag set. cp0_set_exl=1. Go REDIRECT.
  - REDIRECT: one cycle, busy=1, pc_redirect=1, pc_target=EXC_VECTOR. Go IDLE.
  - ERET: one cycle, busy=1, flush=1, pc_redirect=1, pc_target=cp0_epc, cp0_clr_exl=1. Go IDLE.
- Exception latency: request in cycle N → flush from N+1 → COMMIT at N+1+FLUSH_CYCLES → redirect the cycle after.
- ERET latency: redirect at N+1.
- All requests and eret are ignored while busy. Sources must re-assert after the flush.
- Outputs are registered from state; pulses are high for exactly one cycle.
- rst_n asserted mid-sequence: return to IDLE immediately, outputs 0, no CP0 write or redirect issued.

Optional Feature:
Macro IRQ_SYNC_EN.
- Defined: irq passes through a 2-flop synchroniser (reset 0) before int_pend. This adds 2 cycles of interrupt latency.
- Undefined: irq is used directly and must already be synchronous to clk.

Test Plan:
1. id_sys=1, id_pc=32'h0040_0010 for one cycle → flush 2 cycles; COMMIT: cp0_exc_we=1, cp0_epc_o=32'h0040_0010, cp0_exccode=8, cp0_set_exl=1, cp0_bv_we=0; next cycle pc_redirect=1, pc_target=32'hBFC0_0380.
2. mem_ades=1, ex_ov=1, if_adel=1 together, mem_addr=32'h1000_0003 → code 5, cp0_bv_we=1, cp0_badvaddr=32'h1000_0003, EPC=mem_pc.
3. irq[2]=1, status_ie=1, status_exl=0 → code 0, EPC=mem_pc. Repeat with status_exl=1 → no request, stays IDLE.
4. eret=1, cp0_epc=32'h0040_0100 → next cycle flush=1, pc_redirect=1, pc_target=32'h0040_0100, cp0_clr_exl=1. With id_bp=1 in the same cycle → exception sequence instead, no clr_exl.
5. Pulse id_ri during FLUSH → ignored, single COMMIT. Drop rst_n during FLUSH → all outputs 0, no cp0_exc_we or pc_redirect afterwards.
6. With IRQ_SYNC_EN: irq rises at cycle N → flush first seen at N+3.
